sprite_anim_ctrl: RTL

Per-player animation and sprite-fetch controller. Each fighter's sprite ROMs (idle, walk1, walk2, attack; 128x128, 12-bit RGB 4:4:4, 1-cycle registered read) are driven by this block. It sequences the animation state on frame ticks and selects which ROM is active. It also generates the ROM address from the VGA scan position and sprite origin, and aligns the returned pixel with a transparency-qualified valid flag for the pixel mixer.

---
 rtl/sf_sprite_pkg.sv | 16 +
 rtl/sprite_anim_ctrl_if.sv | 27 ++
 rtl/sprite_addr_pipe.sv | 60 ++++++
 rtl/sprite_anim_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/sf_sprite_pkg.sv
// rtl/sf_sprite_pkg.sv - shared sprite encodings, sizes and colour key
package sf_sprite_pkg;

    typedef enum logic [1:0] {
        FRAME_IDLE   = 2'd0,
        FRAME_WALK1  = 2'd1,
        FRAME_WALK2  = 2'd2,
        FRAME_ATTACK = 2'd3
    } frame_e;

    localparam int          SPRITE_W_DEF    = 128;
    localparam int          SPRITE_H_DEF    = 128;
    localparam logic [11:0] TRANSPARENT_KEY = 12'hF0F;
    localparam int          ROM_AW          = 14;

endpackage

// File: rtl/sprite_anim_ctrl_if.sv
// rtl/sprite_anim_ctrl_if.sv - sprite ROM fetch and pixel-mixer bus
interface sprite_anim_ctrl_if;
    import sf_sprite_pkg::*;

    logic [1:0]        frame_sel;
    logic [ROM_AW-1:0] rom_addr;
    logic [11:0]       rom_pixel;
    logic [11:0]       pixel_out;
    logic              pixel_valid;

    modport master (
        output frame_sel,
        output rom_addr,
        input  rom_pixel,
        output pixel_out,
        output pixel_valid
    );

    modport slave (
        input  frame_sel,
        input  rom_addr,
        output rom_pixel,
        input  pixel_out,
        input  pixel_valid
    );

endinterface

// File: rtl/sprite_addr_pipe.sv
// rtl/sprite_addr_pipe.sv - scan-position to ROM address, aligned opaque pixel output
module sprite_addr_pipe
    import sf_sprite_pkg::*;
#(
    parameter int          SPRITE_W    = SPRITE_W_DEF,
    parameter int          SPRITE_H    = SPRITE_H_DEF,
    parameter logic [11:0] TRANSPARENT = TRANSPARENT_KEY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              facing,
    input  logic [11:0]       rom_pixel,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [11:0]       pixel_out,
    output logic              pixel_valid
);

    localparam int CW = $clog2(SPRITE_W);

    logic [10:0]       dx;
    logic [10:0]       dy;
    logic              in_sprite;
    logic [CW-1:0]     col;
    logic [ROM_AW-1:0] addr_next;
    logic              v1;
    logic              v2;
    logic              opaque;

    // 11-bit differences so a sprite hanging off the right/bottom edge never wraps
    assign dx        = {1'b0, hcount} - {1'b0, pos_x};
    assign dy        = {1'b0, vcount} - {1'b0, pos_y};
    assign in_sprite = (hcount >= pos_x) && (dx < 11'(SPRITE_W)) &&
                       (vcount >= pos_y) && (dy < 11'(SPRITE_H));

    // SPRITE_W is a power of two, so SPRITE_W-1-dx is the bitwise inverse
    assign col       = facing ? ~dx[CW-1:0] : dx[CW-1:0];
    assign addr_next = in_sprite ? ((ROM_AW'(dy) << CW) | ROM_AW'(col)) : '0;
    assign opaque    = v2 && (rom_pixel != TRANSPARENT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr    <= '0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
        end else begin
            rom_addr    <= addr_next;
            v1          <= in_sprite;
            v2          <= v1;
            pixel_valid <= opaque;
            pixel_out   <= opaque ? rom_pixel : 12'h000;
        end
    end

endmodule

// File: rtl/sprite_anim_ctrl.sv
// rtl/sprite_anim_ctrl.sv - per-player animation FSM, facing register and sprite fetch
module sprite_anim_ctrl
    import sf_sprite_pkg::*;
#(
    parameter int          SPRITE_W     = SPRITE_W_DEF,
    parameter int          SPRITE_H     = SPRITE_H_DEF,
    parameter int          WALK_PERIOD  = 8,
    parameter int          ATTACK_TICKS = 12,
    parameter logic [11:0] TRANSPARENT  = TRANSPARENT_KEY
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       attack,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    output logic       busy,
    sprite_anim_ctrl_if.master bus
);

    localparam int WCW = $clog2(WALK_PERIOD);
    localparam int ACW = $clog2(ATTACK_TICKS);

    frame_e         state;
    logic [WCW-1:0] walk_cnt;
    logic [ACW-1:0] atk_cnt;
    logic           facing;
    logic           moving;

    assign moving        = move_left ^ move_right;
    assign bus.frame_sel = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FRAME_IDLE;
            walk_cnt <= '0;
            atk_cnt  <= '0;
            facing   <= 1'b0;
            busy     <= 1'b0;
        end else if (frame_tick) begin
            // direction is frozen for the whole attack pose
            if (state != FRAME_ATTACK) begin
                if (move_left && !move_right)
                    facing <= 1'b1;
                else if (move_right && !move_left)
                    facing <= 1'b0;
            end

            if (state == FRAME_ATTACK) begin
                if (atk_cnt == '0) begin
                    state    <= moving ? FRAME_WALK1 : FRAME_IDLE;
                    busy     <= 1'b0;
                    walk_cnt <= '0;
                end else begin
                    atk_cnt <= atk_cnt - 1'b1;
                end
            end else if (attack) begin
                state   <= FRAME_ATTACK;
                atk_cnt <= ACW'(ATTACK_TICKS - 1);
                busy    <= 1'b1;
            end else if (!moving) begin
                state    <= FRAME_IDLE;
                walk_cnt <= '0;
            end else if (state == FRAME_IDLE) begin
                state    <= FRAME_WALK1;
                walk_cnt <= '0;
            end else if (walk_cnt == WCW'(WALK_PERIOD - 1)) begin
                state    <= (state == FRAME_WALK1) ? FRAME_WALK2 : FRAME_WALK1;
                walk_cnt <= '0;
            end else begin
                walk_cnt <= walk_cnt + 1'b1;
            end
        end
    end

    sprite_addr_pipe #(
        .SPRITE_W    (SPRITE_W),
        .SPRITE_H    (SPRITE_H),
        .TRANSPARENT (TRANSPARENT)
    ) u_addr_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .hcount      (hcount),
        .vcount      (vcount),
        .facing      (facing),
        .rom_pixel   (bus.rom_pixel),
        .rom_addr    (bus.rom_addr),
        .pixel_out   (bus.pixel_out),
        .pixel_valid (bus.pixel_valid)
    );

endmodule
